// File: rtl/angle_range_reducer_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared types and helpers for the CORDIC angle front-end.
//   state_e : FSM encoding for angle_range_reducer
//   deg_fix : whole-degree constant expressed in unsigned fixed point
// -----------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WRAP = 2'd1,
    ST_QUAD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Whole degrees shifted into FRAC fractional bits; exact, no rounding.
  function automatic int unsigned deg_fix(input int unsigned deg, input int unsigned frac);
    return deg << frac;
  endfunction

endpackage

// File: rtl/angle_range_reducer_if.sv
// -----------------------------------------------------------------------------
// angle_range_reducer_if
// Handshake/data bundle of the angle range reducer.
//   in_valid/in_ready/phi_veer_in : host side, sign-magnitude angle in degrees
//   out_valid/out_ready           : result handshake towards the CORDIC core
//   phi_veer_out, quarter         : first-quadrant residual and quadrant
//   swap, neg_cos, neg_sin        : reconstruction flags for the back-end
//   range_err                     : unsupported magnitude (no-wrap builds only)
// Modports: slave = reducer, master = host/back-end driving the inputs.
// -----------------------------------------------------------------------------
interface angle_range_reducer_if #(
  parameter int PHI_WIDTH = 22
);

  logic                 in_valid;
  logic                 in_ready;
  logic [PHI_WIDTH-1:0] phi_veer_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [PHI_WIDTH-1:0] phi_veer_out;
  logic [1:0]           quarter;
  logic                 swap;
  logic                 neg_cos;
  logic                 neg_sin;
  logic                 range_err;

  modport slave (
    input  in_valid, phi_veer_in, out_ready,
    output in_ready, out_valid, phi_veer_out, quarter, swap, neg_cos, neg_sin, range_err
  );

  modport master (
    output in_valid, phi_veer_in, out_ready,
    input  in_ready, out_valid, phi_veer_out, quarter, swap, neg_cos, neg_sin, range_err
  );

endinterface

// File: rtl/angle_range_reducer_quadrant_map.sv
// -----------------------------------------------------------------------------
// quadrant_map
// Combinational mapping of a folded angle in [0, 360) degrees to its quadrant,
// first-quadrant residual and cos/sin reconstruction flags.
//   angle_i    : folded magnitude, unsigned fixed point (FRAC_WIDTH frac bits)
//   quarter_o  : 0..3
//   residual_o : angle_i - 90*quarter_o
//   swap_o / neg_cos_o / neg_sin_o : back-end flags
// -----------------------------------------------------------------------------
module quadrant_map
  import cordic_pkg::*;
#(
  parameter int PHI_WIDTH  = 22,
  parameter int FRAC_WIDTH = 12
) (
  input  logic [PHI_WIDTH-2:0] angle_i,
  output logic [1:0]           quarter_o,
  output logic [PHI_WIDTH-2:0] residual_o,
  output logic                 swap_o,
  output logic                 neg_cos_o,
  output logic                 neg_sin_o
);

  localparam int MW = PHI_WIDTH - 1;
  localparam logic [MW-1:0] C90  = MW'(deg_fix(90,  FRAC_WIDTH));
  localparam logic [MW-1:0] C180 = MW'(deg_fix(180, FRAC_WIDTH));
  localparam logic [MW-1:0] C270 = MW'(deg_fix(270, FRAC_WIDTH));

  always_comb begin
    quarter_o  = 2'd0;
    residual_o = angle_i;
    if (angle_i >= C270) begin
      quarter_o  = 2'd3;
      residual_o = angle_i - C270;
    end else if (angle_i >= C180) begin
      quarter_o  = 2'd2;
      residual_o = angle_i - C180;
    end else if (angle_i >= C90) begin
      quarter_o  = 2'd1;
      residual_o = angle_i - C90;
    end
  end

  // q1: swap,neg_cos  q2: neg_cos,neg_sin  q3: swap,neg_sin
  assign swap_o    = quarter_o[0];
  assign neg_cos_o = quarter_o[1] ^ quarter_o[0];
  assign neg_sin_o = quarter_o[1];

endmodule

// File: rtl/angle_range_reducer.sv
// -----------------------------------------------------------------------------
// angle_range_reducer
// Folds a sign-magnitude angle (degrees) into [0, 360), classifies the quadrant
// and emits the first-quadrant residual plus swap/neg_cos/neg_sin flags.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   enable : global enable, freezes FSM and all registers when low
//   bus    : angle_range_reducer_if.slave (valid/ready in, valid/ready out)
// Build option ANGLE_REDUCER_WRAP_EN: when defined, magnitudes >= 360 degrees
// are reduced by repeated subtraction in a WRAP state; when undefined, such
// inputs complete immediately with range_err set and zeroed results.
//
// state   | meaning
// IDLE    | waiting for an input angle, in_ready high
// WRAP    | subtracting 360 degrees until magnitude < 360 (wrap builds only)
// QUAD    | fold, classify, register results, raise out_valid
// DONE    | holding result until out_ready
// -----------------------------------------------------------------------------
module angle_range_reducer
  import cordic_pkg::*;
#(
  parameter int PHI_WIDTH  = 22,
  parameter int FRAC_WIDTH = 12
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  enable,
  angle_range_reducer_if.slave bus
);

  localparam int MW = PHI_WIDTH - 1;
  localparam logic [MW-1:0] C360 = MW'(deg_fix(360, FRAC_WIDTH));

  // Fewer than 9 integer bits cannot represent 360 degrees.
  generate
    if (PHI_WIDTH - 1 - FRAC_WIDTH < 9) begin : g_width_check
      $error("angle_range_reducer: needs at least 9 integer bits");
    end
  endgenerate

  state_e          state_q;
  logic            sign_q;
  logic [MW-1:0]   mag_q;
  logic [MW-1:0]   phi_out_q;
  logic [1:0]      quarter_q;
  logic [2:0]      flags_q;
  logic            range_err_q;
  logic            out_valid_q;

  logic [MW-1:0]   folded;
  logic [MW-1:0]   residual;
  logic [1:0]      quarter;
  logic            swap, neg_cos, neg_sin;

  logic [MW-1:0]   phi_out_d;
  logic [1:0]      quarter_d;
  logic [2:0]      flags_d;
  logic            range_err_d;

  // Negative zero stays at +0 instead of folding to 360.
  assign folded = (sign_q && (mag_q != '0)) ? (C360 - mag_q) : mag_q;

  quadrant_map #(
    .PHI_WIDTH  (PHI_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_quadrant_map (
    .angle_i    (folded),
    .quarter_o  (quarter),
    .residual_o (residual),
    .swap_o     (swap),
    .neg_cos_o  (neg_cos),
    .neg_sin_o  (neg_sin)
  );

  always_comb begin
    phi_out_d   = residual;
    quarter_d   = quarter;
    flags_d     = {swap, neg_cos, neg_sin};
    range_err_d = 1'b0;
`ifdef ANGLE_REDUCER_WRAP_EN
    // WRAP guarantees the magnitude is already below 360 here.
`else
    if (mag_q >= C360) begin
      phi_out_d   = '0;
      quarter_d   = 2'd0;
      flags_d     = 3'b000;
      range_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      phi_out_q   <= '0;
      quarter_q   <= 2'd0;
      flags_q     <= 3'b000;
      range_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_q  <= bus.phi_veer_in[PHI_WIDTH-1];
            mag_q   <= bus.phi_veer_in[MW-1:0];
`ifdef ANGLE_REDUCER_WRAP_EN
            state_q <= ST_WRAP;
`else
            state_q <= ST_QUAD;
`endif
          end
        end
`ifdef ANGLE_REDUCER_WRAP_EN
        ST_WRAP: begin
          if (mag_q >= C360) begin
            mag_q <= mag_q - C360;
          end else begin
            state_q <= ST_QUAD;
          end
        end
`endif
        ST_QUAD: begin
          phi_out_q   <= phi_out_d;
          quarter_q   <= quarter_d;
          flags_q     <= flags_d;
          range_err_q <= range_err_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = rst & enable & (state_q == ST_IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.phi_veer_out = {1'b0, phi_out_q};
  assign bus.quarter      = quarter_q;
  assign bus.swap         = flags_q[2];
  assign bus.neg_cos      = flags_q[1];
  assign bus.neg_sin      = flags_q[0];
  assign bus.range_err    = range_err_q;

endmodule

// File: tb/tb_angle_range_reducer.sv
module tb_angle_range_reducer;

  localparam int PW = 22;
  localparam int FW = 12;
  localparam logic [20:0] C360 = 21'h168000;
`ifdef ANGLE_REDUCER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  angle_range_reducer_if #(.PHI_WIDTH(PW)) bus();

  angle_range_reducer #(
    .PHI_WIDTH  (PW),
    .FRAC_WIDTH (FW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  // Expected values assume wrap-around; no-wrap expectations are derived below.
  typedef struct {
    string       name;
    logic [21:0] phi;
    logic [21:0] out;
    logic [1:0]  q;
    logic [2:0]  f;   // swap, neg_cos, neg_sin
  } vec_t;

  vec_t vecs[15];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic expect_of(input vec_t v, output logic [21:0] eo, output logic [1:0] eq,
                           output logic [2:0] ef, output logic ee, output int el);
    logic big;
    big = (v.phi[20:0] >= C360);
    if (!WRAP && big) begin
      eo = '0; eq = 2'd0; ef = 3'b000; ee = 1'b1; el = 1;
    end else begin
      eo = v.out; eq = v.q; ef = v.f; ee = 1'b0;
      el = WRAP ? (big ? 3 : 2) : 1;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_txn(input logic [21:0] phi);
    int n;
    n = 0;
    bus.phi_veer_in = phi;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input logic [21:0] eo, input logic [1:0] eq,
                              input logic [2:0] ef, input logic ee);
    check({nm, "_out"},   32'(bus.phi_veer_out), 32'(eo));
    check({nm, "_q"},     32'(bus.quarter), 32'(eq));
    check({nm, "_flags"}, 32'({bus.swap, bus.neg_cos, bus.neg_sin}), 32'(ef));
    check({nm, "_err"},   32'(bus.range_err), 32'(ee));
  endtask

  task automatic finish_txn(input string nm);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({nm, "_vld_clr"}, 32'(bus.out_valid), 32'd0);
    check({nm, "_rdy"},     32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] eo;
    logic [1:0]  eq;
    logic [2:0]  ef;
    logic        ee;
    int          el, lat;

    vecs[0]  = '{"p55",    22'h037000, 22'h037000, 2'd0, 3'b000};
    vecs[1]  = '{"p95",    22'h05F000, 22'h005000, 2'd1, 3'b110};
    vecs[2]  = '{"n55",    22'h237000, 22'h023000, 2'd3, 3'b101};
    vecs[3]  = '{"n0",     22'h200000, 22'h000000, 2'd0, 3'b000};
    vecs[4]  = '{"p90",    22'h05A000, 22'h000000, 2'd1, 3'b110};
    vecs[5]  = '{"p180",   22'h0B4000, 22'h000000, 2'd2, 3'b011};
    vecs[6]  = '{"p270",   22'h10E000, 22'h000000, 2'd3, 3'b101};
    vecs[7]  = '{"p360",   22'h168000, 22'h000000, 2'd0, 3'b000};
    vecs[8]  = '{"p450",   22'h1C2000, 22'h000000, 2'd1, 3'b110};
    vecs[9]  = '{"n90",    22'h25A000, 22'h000000, 2'd3, 3'b101};
    vecs[10] = '{"p123_5", 22'h07B800, 22'h021800, 2'd1, 3'b110};
    vecs[11] = '{"n450",   22'h3C2000, 22'h000000, 2'd3, 3'b101};
    vecs[12] = '{"pmax",   22'h1FFFFF, 22'h03DFFF, 2'd1, 3'b110};
    vecs[13] = '{"p360m",  22'h167FFF, 22'h059FFF, 2'd3, 3'b101};
    vecs[14] = '{"n0_5",   22'h200800, 22'h059800, 2'd3, 3'b101};

    // Reset state; enable high so in_ready must be gated by rst.
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.phi_veer_in = '0;
    enable          = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_result("rst", 22'd0, 2'd0, 3'b000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      expect_of(vecs[i], eo, eq, ef, ee, el);
      start_txn(vecs[i].phi);
      wait_valid(lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(el));
      check_result(vecs[i].name, eo, eq, ef, ee);
      finish_txn(vecs[i].name);
    end

    // Back-pressure: result held while out_ready low, enable low blocks handshake
    start_txn(22'h05F000);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      check("hold_vld", 32'(bus.out_valid), 32'd1);
      check("hold_out", 32'(bus.phi_veer_out), 32'h005000);
      check("hold_q", 32'(bus.quarter), 32'd1);
      check("hold_rdy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    enable        = 1'b0;
    @(negedge clk);
    check("dis_done_vld", 32'(bus.out_valid), 32'd1);
    enable = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_vld_clr", 32'(bus.out_valid), 32'd0);
    check("hold_rdy_back", 32'(bus.in_ready), 32'd1);

    // Enable low for 4 cycles right after accept (mid-WRAP in wrap builds)
    expect_of(vecs[8], eo, eq, ef, ee, el);
    start_txn(vecs[8].phi);
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("frz_rdy", 32'(bus.in_ready), 32'd0);
      check("frz_vld", 32'(bus.out_valid), 32'd0);
    end
    enable = 1'b1;
    wait_valid(lat);
    check("frz_lat", 32'(lat + 4), 32'(el + 4));
    check_result("frz", eo, eq, ef, ee);
    finish_txn("frz");

    // Reset mid-operation after a result with non-zero data
    start_txn(22'h037000);
    wait_valid(lat);
    finish_txn("pre_rst");
    check("pre_rst_out", 32'(bus.phi_veer_out), 32'h037000);
    start_txn(vecs[8].phi);
    rst = 1'b0;
    #1;
    check("mrst_rdy", 32'(bus.in_ready), 32'd0);
    check("mrst_vld", 32'(bus.out_valid), 32'd0);
    check_result("mrst", 22'd0, 2'd0, 3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_idle", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mrst_discard", 32'(bus.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
